// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, decode handshake, redirect, halt.
// master = pc_fetch_unit, slave = memory/decode/pc-control side.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output inst_valid, inst, inst_pc,
    input  inst_ready,
    input  redirect, redirect_pc,
    output halted
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  inst_valid, inst, inst_pc,
    output inst_ready,
    output redirect, redirect_pc,
    input  halted
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack, decode handshake, redirect, halt.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] PC_INC      = 16'h0002
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_unit_if.master bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_HALT
  } state_t;

  state_t      state, state_d;
  logic [15:0] pc, pc_d;
  logic [15:0] pend_pc, pend_pc_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] inst_pc_q, inst_pc_d;
  logic        pend, pend_d;
  logic        ack_q;
  logic        ack;

  assign bus.imem_req   = (state == S_REQ) & ~ack_q;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = (state == S_HOLD);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.halted     = (state == S_HALT);

  assign ack = bus.imem_ack & bus.imem_req;

  // ack_q resets high so the first request appears one cycle after rst drops
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      pend      <= 1'b0;
      pend_pc   <= 16'h0000;
      inst_q    <= 16'h0000;
      inst_pc_q <= 16'h0000;
      ack_q     <= 1'b1;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      pend      <= pend_d;
      pend_pc   <= pend_pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      ack_q     <= bus.imem_ack;
    end
  end

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    pend_d    = pend;
    pend_pc_d = pend_pc;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state)
      S_REQ: begin
        if (ack) begin
          pend_d = 1'b0;
          if (bus.redirect) begin
            pc_d = bus.redirect_pc;
          end else if (pend) begin
            pc_d = pend_pc;
          end else begin
            inst_d    = bus.imem_rdata;
            inst_pc_d = pc;
            pc_d      = pc + PC_INC;
            state_d   = S_HOLD;
          end
        end else if (bus.redirect) begin
          // never move addr under an outstanding read
          if (bus.imem_req) begin
            pend_d    = 1'b1;
            pend_pc_d = bus.redirect_pc;
          end else begin
            pc_d   = bus.redirect_pc;
            pend_d = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = S_REQ;
        end else if (bus.inst_ready) begin
          if (inst_q[15:12] == HALT_OPCODE) state_d = S_HALT;
          else                              state_d = S_REQ;
        end
      end
      S_HALT: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if (bus.imem_req && !bus.imem_ack
                 && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scenario bench for pc_fetch_unit: scoreboard of fetched words checked
// at decode accept, plus per-scenario inline checks.
module tb_pc_fetch_unit;

  logic clk;
  logic rst;
  pc_fetch_unit_if bus ();
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  pc_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int checks;
  int failures;
  logic [31:0] sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // decode-side scoreboard: compare on accept, drop on squash
  always @(negedge clk) begin
    logic [31:0] exp;
    if (!rst && bus.inst_valid) begin
      if (bus.redirect) begin
        if (sb.size() > 0) exp = sb.pop_front();
      end else if (bus.inst_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL accept_unexpected got inst=%h pc=%h, none expected",
                   bus.inst, bus.inst_pc);
        end else begin
          exp = sb.pop_front();
          if ({bus.inst, bus.inst_pc} !== exp) begin
            failures++;
            $display("FAIL accept got inst=%h pc=%h expected inst=%h pc=%h",
                     bus.inst, bus.inst_pc, exp[31:16], exp[15:0]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [15:0] exp_addr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_req timeout expected req at %h", exp_addr);
    end else if (bus.imem_addr !== exp_addr) begin
      failures++;
      $display("FAIL req_addr got %h expected %h", bus.imem_addr, exp_addr);
    end
  endtask

  task automatic serve(input int waits, input logic [15:0] rdata,
                       input logic [15:0] exp_addr);
    wait_req(exp_addr);
    for (int i = 0; i < waits; i++) begin
      step();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr) begin
        failures++;
        $display("FAIL req_stable got req=%b addr=%h expected 1 %h",
                 bus.imem_req, bus.imem_addr, exp_addr);
      end
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    sb.push_back({rdata, exp_addr});
    step();
    bus.imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0
        || bus.halted !== 1'b0 || bus.inst !== 16'h0000
        || bus.inst_pc !== 16'h0000) begin
      failures++;
      $display("FAIL reset got req=%b v=%b h=%b inst=%h pc=%h expected 0",
               bus.imem_req, bus.inst_valid, bus.halted,
               bus.inst, bus.inst_pc);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000
        || bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_req got req=%b addr=%h v=%b expected 1 0000 0",
               bus.imem_req, bus.imem_addr, bus.inst_valid);
    end
  endtask

  task automatic test_wait_fetch();
    bus.inst_ready = 1'b1;
    serve(3, 16'h1234, 16'h0000);
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst !== 16'h1234
        || bus.inst_pc !== 16'h0000) begin
      failures++;
      $display("FAIL fetch_out got v=%b inst=%h pc=%h expected 1 1234 0000",
               bus.inst_valid, bus.inst, bus.inst_pc);
    end
    step();
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1
        || bus.imem_addr !== 16'h0002) begin
      failures++;
      $display("FAIL next_req got v=%b req=%b addr=%h expected 0 1 0002",
               bus.inst_valid, bus.imem_req, bus.imem_addr);
    end
`ifdef FETCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd3) begin
      failures++;
      $display("FAIL stall_cnt got %0d expected 3", stall_cnt);
    end
`endif
  endtask

  task automatic test_hold();
    bus.inst_ready = 1'b0;
    serve(0, 16'h2345, 16'h0002);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst !== 16'h2345
          || bus.inst_pc !== 16'h0002 || bus.imem_req !== 1'b0) begin
        failures++;
        $display("FAIL hold got v=%b inst=%h pc=%h req=%b expected 1 2345 0002 0",
                 bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req);
      end
      if (i < 3) step();
    end
    bus.inst_ready = 1'b1;
    step();
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1
        || bus.imem_addr !== 16'h0004) begin
      failures++;
      $display("FAIL hold_release got v=%b req=%b addr=%h expected 0 1 0004",
               bus.inst_valid, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_redirect_pending();
    wait_req(16'h0004);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    step();
    bus.redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0004) begin
        failures++;
        $display("FAIL pend_stable got req=%b addr=%h expected 1 0004",
                 bus.imem_req, bus.imem_addr);
      end
      if (i == 0) step();
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'hBEEF;
    step();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL pend_drop got v=%b req=%b expected 0 0",
               bus.inst_valid, bus.imem_req);
    end
    step();
    wait_req(16'h0040);
  endtask

  task automatic test_halt();
    bus.inst_ready = 1'b1;
    serve(1, 16'hF000, 16'h0040);
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0
          || bus.inst_valid !== 1'b0) begin
        failures++;
        $display("FAIL halt got h=%b req=%b v=%b expected 1 0 0",
                 bus.halted, bus.imem_req, bus.inst_valid);
      end
      step();
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0010;
    step();
    bus.redirect = 1'b0;
    checks++;
    if (bus.halted !== 1'b0 || bus.imem_req !== 1'b1
        || bus.imem_addr !== 16'h0010) begin
      failures++;
      $display("FAIL unhalt got h=%b req=%b addr=%h expected 0 1 0010",
               bus.halted, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    wait_req(16'h0010);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    step();
    bus.redirect = 1'b0;
    step();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'hDEAD;
    step();
    bus.imem_ack = 1'b0;
    serve(0, 16'h1111, 16'hFFFE);
    step();
    wait_req(16'h0000);
  endtask

  task automatic test_back_to_back();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0080;
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = 16'h9999;
    step();
    bus.redirect = 1'b0;
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL ack_redirect got v=%b expected 0", bus.inst_valid);
    end
    step();
    wait_req(16'h0080);
    bus.inst_ready = 1'b0;
    serve(0, 16'h5555, 16'h0080);
    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0020;
    step();
    bus.redirect = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1
        || bus.imem_addr !== 16'h0020) begin
      failures++;
      $display("FAIL squash got v=%b req=%b addr=%h expected 0 1 0020",
               bus.inst_valid, bus.imem_req, bus.imem_addr);
    end
    serve(0, 16'h7777, 16'h0020);
    step();
    wait_req(16'h0022);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0000;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    test_reset();
    test_wait_fetch();
    test_hold();
    test_redirect_pending();
    test_halt();
    test_wrap();
    test_back_to_back();
    step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
